// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with freeze, flush and hazard bubble
// handling, plus saturating stall/flush event counters for performance debug.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  hazard,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [3:0]            id_exe_cmd,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_wb_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic                  id_imm,
    input  logic [11:0]           id_shift_operand,
    input  logic [23:0]           id_signed_imm_24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_carry,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_val_rn,
    output logic [DATA_W-1:0]     ex_val_rm,
    output logic [3:0]            ex_exe_cmd,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_wb_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_imm,
    output logic                  ex_carry,
    output logic [11:0]           ex_shift_operand,
    output logic [23:0]           ex_signed_imm_24,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_src1,
    output logic [REG_ADDR_W-1:0] ex_src2,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic bubble;
    logic stall_evt;
    logic flush_evt;

    assign bubble    = flush | hazard;
    assign stall_evt = freeze | hazard;
    assign flush_evt = flush & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_exe_cmd       <= '0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_b             <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_carry         <= 1'b0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            stall_cnt        <= '0;
            flush_cnt        <= '0;
        end else begin
            if (!freeze) begin
                // Datapath fields load even on a bubble; only control is squashed.
                ex_pc            <= id_pc;
                ex_val_rn        <= id_val_rn;
                ex_val_rm        <= id_val_rm;
                ex_imm           <= id_imm;
                ex_carry         <= id_carry;
                ex_shift_operand <= id_shift_operand;
                ex_signed_imm_24 <= id_signed_imm_24;
                ex_dest          <= id_dest;
                ex_src1          <= id_src1;
                ex_src2          <= id_src2;
                if (bubble) begin
                    ex_valid     <= 1'b0;
                    ex_exe_cmd   <= '0;
                    ex_mem_read  <= 1'b0;
                    ex_mem_write <= 1'b0;
                    ex_wb_en     <= 1'b0;
                    ex_b         <= 1'b0;
                    ex_s         <= 1'b0;
                end else begin
                    ex_valid     <= id_valid;
                    ex_exe_cmd   <= id_exe_cmd;
                    ex_mem_read  <= id_mem_read  & id_valid;
                    ex_mem_write <= id_mem_write & id_valid;
                    ex_wb_en     <= id_wb_en     & id_valid;
                    ex_b         <= id_b         & id_valid;
                    ex_s         <= id_s         & id_valid;
                end
            end
            // Counters keep running while freeze holds the pipeline.
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
